// File: rtl/ysyx_23060203_lsu_pkg.sv
// Shared encodings for the LSU: funct3 codes, FSM states and the request legality check.
// Define YSYX_23060203_LSU_MISALIGN_CHK_EN to fault misaligned halfword/word accesses.
package ysyx_23060203_lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned FUNC_W = 3;

    localparam logic [FUNC_W-1:0] FUNCT3_B  = 3'b000;
    localparam logic [FUNC_W-1:0] FUNCT3_H  = 3'b001;
    localparam logic [FUNC_W-1:0] FUNCT3_W  = 3'b010;
    localparam logic [FUNC_W-1:0] FUNCT3_BU = 3'b100;
    localparam logic [FUNC_W-1:0] FUNCT3_HU = 3'b101;

`ifdef YSYX_23060203_LSU_MISALIGN_CHK_EN
    localparam bit MISALIGN_CHK = 1'b1;
`else
    localparam bit MISALIGN_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    // 1 when the request must be answered with an error and no memory access
    function automatic logic func_fault(input logic i_wen, input logic [FUNC_W-1:0] i_func,
                                        input logic [1:0] i_addr_lo);
        logic r_bad;
        case (i_func)
            FUNCT3_B:  r_bad = 1'b0;
            FUNCT3_H:  r_bad = MISALIGN_CHK & i_addr_lo[0];
            FUNCT3_W:  r_bad = MISALIGN_CHK & (i_addr_lo != 2'b00);
            FUNCT3_BU: r_bad = i_wen;
            FUNCT3_HU: r_bad = i_wen | (MISALIGN_CHK & i_addr_lo[0]);
            default:   r_bad = 1'b1;
        endcase
        return r_bad;
    endfunction

endpackage

// File: rtl/ysyx_23060203_LSU_Fmt.sv
// Store lane/strobe generation and load extraction/extension; purely combinational.
module ysyx_23060203_LSU_Fmt
    import ysyx_23060203_lsu_pkg::*;
(
    input  logic [FUNC_W-1:0] i_func,
    input  logic [1:0]        i_addr_lo,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        case (i_func[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_rdata = i_rdata;
        case (i_func)
            FUNCT3_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
            FUNCT3_BU: o_rdata = {24'd0, w_byte};
            FUNCT3_H:  o_rdata = {{16{w_half[15]}}, w_half};
            FUNCT3_HU: o_rdata = {16'd0, w_half};
            default:   ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060203_lsu.sv
// Load/store unit: one EXU request in flight, bridged to a valid/ready memory port.
// YSYX_23060203_LSU_MISALIGN_CHK_EN (see package) enables misaligned-access faults.
module ysyx_23060203_lsu
    import ysyx_23060203_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [FUNC_W-1:0] req_func,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err
);

    lsu_state_e        r_state;
    logic              r_wen;
    logic [FUNC_W-1:0] r_func;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              r_mem_req_valid;
    logic              r_mem_rsp_ready;
    logic              r_resp_valid;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;

    logic [STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]   w_st_data;
    logic [XLEN-1:0]   w_ld_data;

    ysyx_23060203_LSU_Fmt u_fmt (
        .i_func    (r_func),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_rsp_rdata),
        .o_wstrb   (w_wstrb),
        .o_wdata   (w_st_data),
        .o_rdata   (w_ld_data)
    );

    // Memory request fields decode only latched registers, so they hold steady through REQ
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_wen   = r_wen;
    assign mem_req_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign mem_req_wdata = w_st_data;
    assign mem_req_wstrb = r_wen ? w_wstrb : 4'b0000;
    assign mem_rsp_ready = r_mem_rsp_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_err      = r_resp_err;

    // Gated by rst so the port reads 0 during reset yet is 1 on the first cycle after it
    assign req_ready = (r_state == S_IDLE) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_wen           <= 1'b0;
            r_func          <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_rsp_ready <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_resp_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wen   <= req_wen;
                        r_func  <= req_func;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (func_fault(req_wen, req_func, req_addr[1:0])) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state         <= S_REQ;
                            r_mem_req_valid <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state         <= S_WAIT;
                        r_mem_req_valid <= 1'b0;
                        r_mem_rsp_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state         <= S_RESP;
                        r_mem_rsp_ready <= 1'b0;
                        r_resp_valid    <= 1'b1;
                        r_resp_rdata    <= r_wen ? '0 : w_ld_data;
                        r_resp_err      <= mem_rsp_err;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_lsu.sv
// Randomized self-checking bench for ysyx_23060203_lsu against a byte-lane arithmetic model.
module tb_ysyx_23060203_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_func;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;

`ifdef YSYX_23060203_LSU_MISALIGN_CHK_EN
    localparam bit CHK_ALIGN = 1'b1;
`else
    localparam bit CHK_ALIGN = 1'b0;
`endif

    ysyx_23060203_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_func(req_func), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Access size in bytes from funct3
    function automatic int acc_size(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Byte offset of the accessed lane (natural alignment of the size inside the word)
    function automatic int lane_off(input logic [2:0] f, input logic [31:0] a);
        int sz;
        sz = acc_size(f);
        return (int'(a[1:0]) / sz) * sz;
    endfunction

    function automatic bit exp_fault(input logic wen, input logic [2:0] f, input logic [31:0] a);
        bit bad;
        bad = (f == 3'd3) || (f >= 3'd6) || (wen && f[2]);
        if (CHK_ALIGN && (a % 32'(acc_size(f))) != 32'd0) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f, input logic [31:0] a);
        int sz;
        logic [7:0] m;
        sz = acc_size(f);
        m  = ((8'd1 << sz) - 8'd1) << lane_off(f, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] d);
        case (acc_size(f))
            1:       return 32'(d[7:0]) * 32'h01010101;
            2:       return 32'(d[15:0]) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] word);
        int sz;
        logic [31:0] mask, v;
        sz   = acc_size(f);
        mask = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (word >> (8 * lane_off(f, a))) & mask;
        if (!f[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // One full transaction with programmable stalls on every handshake
    task automatic do_txn(input logic wen, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] word, input logic merr,
                          input int req_dly, input int rsp_dly, input int resp_dly);
        logic [31:0] e_rd;
        logic        e_err;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wen = wen; req_func = f; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_func = 3'($urandom);
        if (exp_fault(wen, f, a)) begin
            chk("flt_no_mem", 32'(mem_req_valid), 32'd0);
            e_rd  = 32'd0;
            e_err = 1'b1;
        end else begin
            for (int i = 0; i <= req_dly; i++) begin
                chk("mreq_valid", 32'(mem_req_valid), 32'd1);
                chk("mreq_addr", mem_req_addr, {a[31:2], 2'b00});
                chk("mreq_wen", 32'(mem_req_wen), 32'(wen));
                chk("mreq_wstrb", 32'(mem_req_wstrb), wen ? 32'(exp_strb(f, a)) : 32'd0);
                if (wen) chk("mreq_wdata", mem_req_wdata, exp_wdata(f, d));
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                chk("mrsp_ready_req", 32'(mem_rsp_ready), 32'd0);
                if (i == req_dly) begin
                    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
                end else begin
                    mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom;
                end
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i <= rsp_dly; i++) begin
                chk("mrsp_ready", 32'(mem_rsp_ready), 32'd1);
                chk("mreq_drop", 32'(mem_req_valid), 32'd0);
                chk("resp_early", 32'(resp_valid), 32'd0);
                if (i == rsp_dly) begin
                    mem_req_ready = 1'b0;
                    mem_rsp_valid = 1'b1; mem_rsp_rdata = word; mem_rsp_err = merr;
                end else begin
                    mem_req_ready = 1'($urandom);
                end
                @(negedge clk);
            end
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_rdata = $urandom;
            e_rd  = wen ? 32'd0 : exp_load(f, a, word);
            e_err = merr;
        end
        for (int i = 0; i <= resp_dly; i++) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_rdata", resp_rdata, e_rd);
            chk("resp_err", 32'(resp_err), 32'(e_err));
            chk("req_ready_resp", 32'(req_ready), 32'd0);
            chk("mrsp_ready_resp", 32'(mem_rsp_ready), 32'd0);
            if (i == resp_dly) resp_ready = 1'b1;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        chk("resp_done", 32'(resp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        chk({tag, "_mreq_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_mreq_wen"}, 32'(mem_req_wen), 32'd0);
        chk({tag, "_mreq_addr"}, mem_req_addr, 32'd0);
        chk({tag, "_mreq_wdata"}, mem_req_wdata, 32'd0);
        chk({tag, "_mreq_wstrb"}, 32'(mem_req_wstrb), 32'd0);
        chk({tag, "_mrsp_ready"}, 32'(mem_rsp_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_func = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        resp_ready = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0; mem_rsp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        #1;
        chk("req_ready_after_rst", 32'(req_ready), 32'd1);

        // Directed cases, including the minimum-latency path (all stalls 0)
        do_txn(1'b1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0, 0);
        do_txn(1'b1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0, 1'b0, 0, 0, 0);
        do_txn(1'b0, 3'b000, 32'h80000002, 32'h0, 32'h12F43456, 1'b0, 0, 0, 0);
        do_txn(1'b0, 3'b100, 32'h80000002, 32'h0, 32'h12F43456, 1'b0, 0, 0, 0);
        do_txn(1'b0, 3'b010, 32'h80000002, 32'h0, 32'h12F43456, 1'b0, 0, 0, 0);
        do_txn(1'b1, 3'b010, 32'h80000010, 32'hCAFEF00D, 32'h0, 1'b0, 5, 0, 3);
        do_txn(1'b1, 3'b001, 32'h80000006, 32'h0000BEEF, 32'h0, 1'b0, 1, 1, 1);
        do_txn(1'b0, 3'b101, 32'h80000002, 32'h0, 32'h8001FFFF, 1'b0, 0, 2, 0);
        do_txn(1'b0, 3'b001, 32'h80000000, 32'h0, 32'h12348765, 1'b1, 0, 0, 0);
        do_txn(1'b1, 3'b100, 32'h80000000, 32'h11, 32'h0, 1'b0, 0, 0, 1);
        do_txn(1'b0, 3'b011, 32'h80000000, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        do_txn(1'b0, 3'b111, 32'h80000001, 32'h0, 32'h0, 1'b0, 0, 0, 0);

        // Reset pulse while waiting on memory, then a stray response
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_func = 3'b010;
        req_addr = 32'h80000010; req_wdata = 32'h55AA55AA;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("wait_before_rst", 32'(mem_rsp_ready), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_in_wait");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("req_ready_after_pulse", 32'(req_ready), 32'd1);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFFFFFF; mem_rsp_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_rsp_valid", 32'(resp_valid), 32'd0);
            chk("stray_rsp_ready", 32'(mem_rsp_ready), 32'd0);
        end
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;

        for (int n = 0; n < 80; n++) begin
            do_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_lsu.md
YSYX_23060203_LSU -- requirements
Module: ysyx_23060203_LSU

Interface
REQ-001 No parameters; data and address widths are fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req_valid  in  1  EXU access request present.
REQ-005 req_ready  out  1  LSU accepts a request.
REQ-006 req_wen  in  1  1=store, 0=load.
REQ-007 req_func  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  result available to EXU.
REQ-011 resp_ready  in  1  EXU consumes the result.
REQ-012 resp_rdata  out  32  load result, extended; 0 for stores.
REQ-013 resp_err  out  1  access fault.
REQ-014 mem_req_valid / mem_req_ready  out / in  1  memory request handshake.
REQ-015 mem_req_wen  out  1  memory write.
REQ-016 mem_req_addr  out  32  word-aligned address {req_addr[31:2],2'b00}.
REQ-017 mem_req_wdata  out  32  lane-shifted store data.
REQ-018 mem_req_wstrb  out  4  byte strobes; 4'b0000 for loads.
REQ-019 mem_rsp_valid / mem_rsp_ready  in / out  1  memory response handshake.
REQ-020 mem_rsp_rdata  in  32  raw read word.
REQ-021 mem_rsp_err  in  1  memory-reported fault.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, RESP; one request in flight at a time.
REQ-023 req_ready=1 only in IDLE; req_valid&&req_ready latches wen, func, addr, wdata and moves to REQ.
REQ-024 REQ: mem_req_valid=1 with stable fields until mem_req_ready; on handshake move to WAIT.
REQ-025 WAIT: mem_rsp_ready=1; on mem_rsp_valid latch the formatted data and mem_rsp_err, then move to RESP.
REQ-026 RESP: resp_valid=1 with stable outputs until resp_ready, then IDLE.
REQ-027 Minimum latency: accept at cycle 0, mem_req_valid at cycle 1, resp_valid at cycle 3; back-to-back requests accepted no sooner than the cycle after resp handshake.
REQ-028 Store lanes: sb strobe 4'b0001<<addr[1:0], wdata byte replicated x4; sh strobe 4'b0011<<{addr[1],1'b0}, halfword replicated x2; sw strobe 4'b1111.
REQ-029 Load extract: b/bu select the byte at addr[1:0], h/hu select the halfword at addr[1]; b and h sign-extend, bu and hu zero-extend, w passes through.
REQ-030 Invalid func (011, 110, 111, or bu/hu on a store): IDLE moves directly to RESP with resp_err=1 and resp_rdata=0; no memory transaction.
REQ-031 A mem_rsp_valid arriving outside WAIT is ignored; mem_req_ready outside REQ is ignored.

Reset
REQ-032 rst asserted forces IDLE immediately; all valid/ready outputs, resp_rdata, resp_err, and mem_req_* data fields read 0; an in-flight access is abandoned without response.
REQ-033 After rst deasserts, req_ready=1 on the first cycle.

Configuration
REQ-034 Macro YSYX_23060203_LSU_MISALIGN_CHK_EN defined: h/hu with addr[0]!=0, or w with addr[1:0]!=0, behaves as REQ-030 (error, no memory access); undefined: the low address bits are ignored and the access proceeds on the aligned word.

Structure
REQ-035 Shared package/include holds the funct3 encodings and FSM state encodings.
REQ-036 One combinational sub-module, ysyx_23060203_LSU_Fmt, implements store lane/strobe generation and load extraction.

Verification
REQ-037 sw addr 0x80000004, data 0xDEADBEEF -> mem addr 0x80000004, wstrb 1111, wdata 0xDEADBEEF, resp_err=0.
REQ-038 sb addr 0x80000003, data 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5.
REQ-039 lb and lbu addr 0x80000002 with memory word 0x12F43456 -> resp_rdata 0xFFFFFFF4 and 0x000000F4 respectively.
REQ-040 lw addr 0x80000002: macro defined -> resp_err=1 with no mem_req_valid; undefined -> aligned word returned, resp_err=0.
REQ-041 mem_req_ready held low for 5 cycles, then resp_ready held low for 3 cycles -> request fields and response outputs stay stable; req_ready=0 throughout.
REQ-042 rst pulsed while in WAIT -> all outputs read 0 immediately; a later stray mem_rsp_valid produces no resp_valid.
